text_overlay: RTL and testbench
===============================

Name: text_overlay

Overview:
- Text-overlay stage directly upstream of the 8x8 font ROM.
- Per VGA pixel it computes which character cell the pixel falls in and drives char_addr/row_addr to the ROM. It then registers the returned bitmap row and emits a pipelined text_on pixel flag for the colour mapper.
- It owns the HUD strings: line 0 is "SCORE:dddd LIVES:d"; line 1 is "PRESS ANY KEY".
- A multi-cycle binary-to-BCD converter turns the score into digits for line 0.

Parameters:
- SCALE_LOG2, 1, glyph magnification as a power of two; on-screen cell is G = 8<<SCALE_LOG2 pixels square.
- HUD_X0, 8, left pixel column of line 0.
- HUD_Y0, 8, top pixel row of line 0.
- MSG_X0, 216, left pixel column of line 1.
- MSG_Y0, 232, top pixel row of line 1.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- draw_x  in  10  current pixel column
- draw_y  in  10  current pixel row
- pix_valid  in  1  draw_x/draw_y are in the active area
- score  in  14  binary score
- score_load  in  1  one-cycle request to convert score
- lives  in  3  lives remaining, shown as one digit
- show_prompt  in  1  enables line 1
- char_addr  out  8  ASCII code to the font ROM
- row_addr  out  3  glyph row to the font ROM
- bitmap  in  8  ROM row data; combinational from char_addr/row_addr; MSB is the leftmost pixel
- text_on  out  1  pixel lies on a lit glyph bit
- text_valid  out  1  pix_valid delayed to align with text_on
- bcd_busy  out  1  conversion in progress

Behaviour:
- Reset (async, rst_n=0):
  - char_addr=0x20, row_addr=0, text_on=0, text_valid=0, bcd_busy=0.
  - Displayed digits = 0000; converter FSM = IDLE.
- BCD converter FSM: IDLE -> SHIFT -> IDLE.
  - IDLE accepting score_load=1: latch min(score, 9999), clear the BCD accumulator, set bcd_busy, enter SHIFT.
  - SHIFT runs exactly 14 double-dabble iterations, one per cycle. Each iteration adds 3 to every BCD nibble >=5, then shifts left one bit.
  - After the 14th iteration, the four digits are copied atomically into the displayed-digit register, bcd_busy drops the same cycle, and the FSM returns to IDLE.
  - Timing: bcd_busy is high for cycles 1..14 after the load cycle. Displayed digits change at the edge ending cycle 14.
  - score_load while busy is ignored; no queueing.
  - Reset mid-conversion aborts the conversion; digits return to 0000.
  - Leading zeros are displayed as '0'.
- Lives digit = 0x30 + lives, sampled live. lives=0 shows '0'.
- Character strings:
  - Line 0 has 18 columns: S C O R E : d3 d2 d1 d0 space L I V E S : lives. d3 is the thousands digit; digit ASCII = 0x30 + nibble.
  - Line 1 has 13 columns: P R E S S space A N Y space K E Y.
- Cell decode, per line (X0, Y0, N = 18 or 13):
  - Region: relx = draw_x - X0, rely = draw_y - Y0.
  - Hit condition: draw_x >= X0, draw_y >= Y0, rely < G, and col = relx >> (3+SCALE_LOG2) < N.
  - Line 1 additionally requires show_prompt.
  - Glyph row = (rely >> SCALE_LOG2)[2:0]; bit index = (relx >> SCALE_LOG2)[2:0].
  - Line 0 has priority if the two regions overlap.
- Pipeline: fixed latency of 2 cycles, independent of content.
  - Stage 1 (edge 1):
    - On a hit, register char_addr = string[col] and row_addr = glyph row; also register bit index, hit, and pix_valid.
    - On a miss, char_addr = 0x20, row_addr = 0, hit = 0.
  - Stage 2 (edge 2): text_on = hit & bitmap[7 - bit index]; text_valid = stage-1 pix_valid.
  - With pix_valid=0, stage 1 forces hit=0, so text_on is 0 two cycles later.
  - The pipeline advances every cycle; there is no stall.
- Arithmetic: relx and rely are computed 11 bits wide so that coordinates below X0/Y0 produce a miss and never wrap into a hit.

Test Plan:
- Reset: hold rst_n=0 mid-frame -> all outputs at reset values; after release with no load, line 0 column 6 (draw_x=104, draw_y=8) gives char_addr=0x30.
- Conversion: score=1234, pulse score_load -> bcd_busy high exactly 14 cycles. Afterwards columns 6..9 (draw_x=104,120,136,152; draw_y=8) give char_addr 0x31, 0x32, 0x33, 0x34.
- Saturation and ignored load: score=12000 gives 9999 (0x39 x4). A second load at busy cycle 5 with score=7 is ignored; the result is still 9999.
- Pixel path: draw_x=8, draw_y=8 -> char_addr=0x53, row_addr=0 after 1 cycle. A ROM model returning 0x7C gives text_on=0 at cycle 2 (bit 7 = 0); draw_x=10 gives text_on=1.
- Prompt gating: draw_x=216, draw_y=232, show_prompt=0 -> char_addr=0x20, text_on=0; with show_prompt=1 -> char_addr=0x50.
- Bounds and lives: draw_x=296 (col 18), draw_y=8 -> miss, text_on=0. lives=3 at col 17 (draw_x=280) -> char_addr=0x33. pix_valid=0 -> text_on=0 and text_valid=0 two cycles later.

Source files
------------

// File: rtl/text_overlay.sv
// HUD text overlay: maps each pixel to a character cell, addresses the 8x8 font ROM and
// emits a two-stage pipelined text_on flag. Also converts the score to BCD for line 0.
module text_overlay #(
   parameter int SCALE_LOG2 = 1,
   parameter int HUD_X0     = 8,
   parameter int HUD_Y0     = 8,
   parameter int MSG_X0     = 216,
   parameter int MSG_Y0     = 232
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [9:0]  draw_x,
   input  logic [9:0]  draw_y,
   input  logic        pix_valid,
   input  logic [13:0] score,
   input  logic        score_load,
   input  logic [2:0]  lives,
   input  logic        show_prompt,
   output logic [7:0]  char_addr,
   output logic [2:0]  row_addr,
   input  logic [7:0]  bitmap,
   output logic        text_on,
   output logic        text_valid,
   output logic        bcd_busy
);

   localparam int G      = 8 << SCALE_LOG2;
   localparam int CSH    = 3 + SCALE_LOG2;
   localparam int LINE0_N = 18;
   localparam int LINE1_N = 13;
   localparam logic [13:0] SCORE_MAX = 14'd9999;
   localparam logic [3:0]  LAST_ITER = 4'd13;
   localparam logic [7:0]  ASCII_SPACE = 8'h20;
   localparam logic [7:0]  ASCII_ZERO  = 8'h30;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } bcd_state_t;

   // One double-dabble iteration: add 3 to every nibble >= 5, then shift in the next binary bit.
   function automatic logic [15:0] dabble_step(input logic [15:0] acc, input logic in_bit);
      logic [15:0] adj;
      adj = acc;
      for (int i = 0; i < 4; i++) begin
         if (adj[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
         end else begin
            adj[4*i +: 4] = adj[4*i +: 4];
         end
      end
      return {adj[14:0], in_bit};
   endfunction

   function automatic logic [7:0] line0_char(input logic [4:0] col, input logic [15:0] dig,
                                             input logic [2:0] lv);
      logic [7:0] c;
      case (col)
         5'd0:    c = 8'h53;
         5'd1:    c = 8'h43;
         5'd2:    c = 8'h4F;
         5'd3:    c = 8'h52;
         5'd4:    c = 8'h45;
         5'd5:    c = 8'h3A;
         5'd6:    c = ASCII_ZERO + {4'h0, dig[15:12]};
         5'd7:    c = ASCII_ZERO + {4'h0, dig[11:8]};
         5'd8:    c = ASCII_ZERO + {4'h0, dig[7:4]};
         5'd9:    c = ASCII_ZERO + {4'h0, dig[3:0]};
         5'd10:   c = ASCII_SPACE;
         5'd11:   c = 8'h4C;
         5'd12:   c = 8'h49;
         5'd13:   c = 8'h56;
         5'd14:   c = 8'h45;
         5'd15:   c = 8'h53;
         5'd16:   c = 8'h3A;
         5'd17:   c = ASCII_ZERO + {5'b00000, lv};
         default: c = ASCII_SPACE;
      endcase
      return c;
   endfunction

   function automatic logic [7:0] line1_char(input logic [4:0] col);
      logic [7:0] c;
      case (col)
         5'd0:    c = 8'h50;
         5'd1:    c = 8'h52;
         5'd2:    c = 8'h45;
         5'd3:    c = 8'h53;
         5'd4:    c = 8'h53;
         5'd5:    c = ASCII_SPACE;
         5'd6:    c = 8'h41;
         5'd7:    c = 8'h4E;
         5'd8:    c = 8'h59;
         5'd9:    c = ASCII_SPACE;
         5'd10:   c = 8'h4B;
         5'd11:   c = 8'h45;
         5'd12:   c = 8'h59;
         default: c = ASCII_SPACE;
      endcase
      return c;
   endfunction

   bcd_state_t  state_r;
   logic [13:0] bin_r;
   logic [15:0] acc_r;
   logic [3:0]  iter_r;
   logic [15:0] digits_r;
   logic [15:0] acc_next_s;

   assign acc_next_s = dabble_step(acc_r, bin_r[13]);

   // Score-to-BCD converter; displayed digits only change when a full conversion completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= S_IDLE;
         bin_r    <= 14'd0;
         acc_r    <= 16'd0;
         iter_r   <= 4'd0;
         digits_r <= 16'd0;
         bcd_busy <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (score_load) begin
                  bin_r    <= (score > SCORE_MAX) ? SCORE_MAX : score;
                  acc_r    <= 16'd0;
                  iter_r   <= 4'd0;
                  bcd_busy <= 1'b1;
                  state_r  <= S_SHIFT;
               end else begin
                  bcd_busy <= 1'b0;
               end
            end
            S_SHIFT: begin
               acc_r  <= acc_next_s;
               bin_r  <= {bin_r[12:0], 1'b0};
               iter_r <= iter_r + 4'd1;
               if (iter_r == LAST_ITER) begin
                  digits_r <= acc_next_s;
                  bcd_busy <= 1'b0;
                  state_r  <= S_IDLE;
               end else begin
                  bcd_busy <= 1'b1;
               end
            end
            default: begin
               bcd_busy <= 1'b0;
               state_r  <= S_IDLE;
            end
         endcase
      end
   end

   // 11-bit offsets: a pixel left of / above a line's origin goes negative and fails the bound test.
   logic [10:0] relx0_s, rely0_s, relx1_s, rely1_s;
   logic        in0_s, in1_s;

   assign relx0_s = {1'b0, draw_x} - 11'(HUD_X0);
   assign rely0_s = {1'b0, draw_y} - 11'(HUD_Y0);
   assign relx1_s = {1'b0, draw_x} - 11'(MSG_X0);
   assign rely1_s = {1'b0, draw_y} - 11'(MSG_Y0);

   assign in0_s = (draw_x >= 10'(HUD_X0)) && (draw_y >= 10'(HUD_Y0)) &&
                  (rely0_s < 11'(G)) && ((relx0_s >> CSH) < 11'(LINE0_N));
   assign in1_s = (draw_x >= 10'(MSG_X0)) && (draw_y >= 10'(MSG_Y0)) &&
                  (rely1_s < 11'(G)) && ((relx1_s >> CSH) < 11'(LINE1_N));

   logic [7:0] char_s;
   logic [2:0] row_s;
   logic [2:0] bit_s;
   logic       hit_s;

   // Cell lookup; line 0 wins where the two regions overlap.
   always_comb begin
      char_s = ASCII_SPACE;
      row_s  = 3'd0;
      bit_s  = 3'd0;
      hit_s  = 1'b0;
      if (pix_valid && in0_s) begin
         char_s = line0_char(relx0_s[CSH +: 5], digits_r, lives);
         row_s  = rely0_s[SCALE_LOG2 +: 3];
         bit_s  = relx0_s[SCALE_LOG2 +: 3];
         hit_s  = 1'b1;
      end else if (pix_valid && show_prompt && in1_s) begin
         char_s = line1_char(relx1_s[CSH +: 5]);
         row_s  = rely1_s[SCALE_LOG2 +: 3];
         bit_s  = relx1_s[SCALE_LOG2 +: 3];
         hit_s  = 1'b1;
      end else begin
         hit_s  = 1'b0;
      end
   end

   logic [2:0] bit_r;
   logic       hit_r;
   logic       pv_r;

   // Stage 1: font ROM address plus the side information needed to pick the glyph bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         char_addr <= ASCII_SPACE;
         row_addr  <= 3'd0;
         bit_r     <= 3'd0;
         hit_r     <= 1'b0;
         pv_r      <= 1'b0;
      end else begin
         char_addr <= char_s;
         row_addr  <= row_s;
         bit_r     <= bit_s;
         hit_r     <= hit_s;
         pv_r      <= pix_valid;
      end
   end

   // Stage 2: select the glyph bit from the ROM row (MSB is the leftmost pixel).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         text_on    <= 1'b0;
         text_valid <= 1'b0;
      end else begin
         text_on    <= hit_r & bitmap[3'd7 - bit_r];
         text_valid <= pv_r;
      end
   end

endmodule

// File: tb/tb_text_overlay.sv
// Self-checking bench for text_overlay: directed scenarios plus randomized pixels and scores
// compared against a string-based reference model of the HUD.
module tb_text_overlay;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  draw_x = 10'd0;
   logic [9:0]  draw_y = 10'd0;
   logic        pix_valid = 1'b0;
   logic [13:0] score = 14'd0;
   logic        score_load = 1'b0;
   logic [2:0]  lives = 3'd0;
   logic        show_prompt = 1'b0;
   logic [7:0]  char_addr;
   logic [2:0]  row_addr;
   logic [7:0]  bitmap;
   logic        text_on;
   logic        text_valid;
   logic        bcd_busy;

   int  errors = 0;
   int  checks = 0;
   bit  rom_fixed = 1'b0;
   int  exp_score = 0;
   logic [7:0] last_ch;
   logic [2:0] last_row;
   logic       last_on;
   logic       last_tv;

   text_overlay dut (
      .clk(clk), .rst_n(rst_n), .draw_x(draw_x), .draw_y(draw_y), .pix_valid(pix_valid),
      .score(score), .score_load(score_load), .lives(lives), .show_prompt(show_prompt),
      .char_addr(char_addr), .row_addr(row_addr), .bitmap(bitmap), .text_on(text_on),
      .text_valid(text_valid), .bcd_busy(bcd_busy)
   );

   always #5 clk = ~clk;

   // Font ROM stand-in: fixed 0x7C row for directed bit tests, otherwise a char/row hash.
   function automatic logic [7:0] rom_f(input logic [7:0] c, input logic [2:0] r, input bit fixed);
      if (fixed) return 8'h7C;
      return c ^ {r, r, 2'b10};
   endfunction

   assign bitmap = rom_f(char_addr, row_addr, rom_fixed);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: build the HUD strings as text and index them by cell.
   task automatic model(input int x, input int y, input bit pv, output logic [7:0] ch,
                        output logic [2:0] row, output logic on);
      string s0, s1;
      int    col, r, bi;
      bit    hit;
      logic [7:0] b;
      s0 = $sformatf("SCORE:%04d LIVES:%0d", exp_score, int'(lives));
      s1 = "PRESS ANY KEY";
      ch = 8'h20; r = 0; bi = 0; hit = 1'b0; on = 1'b0;
      if (pv && x >= 8 && y >= 8 && (y - 8) < 16 && (x - 8) / 16 < 18) begin
         col = (x - 8) / 16;
         ch = s0[col]; r = ((y - 8) / 2) % 8; bi = ((x - 8) / 2) % 8; hit = 1'b1;
      end else if (pv && show_prompt && x >= 216 && y >= 232 && (y - 232) < 16 &&
                   (x - 216) / 16 < 13) begin
         col = (x - 216) / 16;
         ch = s1[col]; r = ((y - 232) / 2) % 8; bi = ((x - 216) / 2) % 8; hit = 1'b1;
      end
      row = r[2:0];
      if (hit) begin
         b = rom_f(ch, row, rom_fixed);
         on = b[7 - bi];
      end
   endtask

   // Present one pixel (called at a negedge), check stage 1 then stage 2.
   task automatic step(input string tag, input int x, input int y, input bit pv);
      logic [7:0] ech;
      logic [2:0] erow;
      logic       eon;
      draw_x = 10'(x); draw_y = 10'(y); pix_valid = pv;
      model(x, y, pv, ech, erow, eon);
      @(negedge clk);
      chk({tag, ".char"}, 32'(char_addr), 32'(ech));
      chk({tag, ".row"}, 32'(row_addr), 32'(erow));
      last_ch = char_addr; last_row = row_addr;
      @(negedge clk);
      chk({tag, ".on"}, 32'(text_on), 32'(eon));
      chk({tag, ".tvalid"}, 32'(text_valid), 32'(pv));
      last_on = text_on; last_tv = text_valid;
   endtask

   // Pulse score_load, measure busy length; optionally retry a load at busy cycle 5.
   task automatic load(input int sc, input bit inject);
      int nb;
      score = 14'(sc); score_load = 1'b1;
      @(negedge clk);
      score_load = 1'b0; nb = 0;
      while (bcd_busy && nb < 40) begin
         nb++;
         if (inject && nb == 5) begin
            score = 14'd7; score_load = 1'b1;
         end else begin
            score_load = 1'b0;
         end
         @(negedge clk);
      end
      score_load = 1'b0;
      chk("busy_len", 32'(nb), 32'd14);
      exp_score = (sc > 9999) ? 9999 : sc;
   endtask

   initial begin
      int x, y, sel;
      draw_x = 10'd104; draw_y = 10'd8; pix_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst.char", 32'(char_addr), 32'h20);
      chk("rst.row", 32'(row_addr), 32'd0);
      chk("rst.on", 32'(text_on), 32'd0);
      chk("rst.tvalid", 32'(text_valid), 32'd0);
      chk("rst.busy", 32'(bcd_busy), 32'd0);
      rst_n = 1'b1;
      step("rst_col6", 104, 8, 1'b1);
      chk("rst_digit0", 32'(last_ch), 32'h30);

      load(1234, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step("d1234", 104 + 16 * i, 8, 1'b1);
         chk("d1234_const", 32'(last_ch), 32'h31 + 32'(i));
      end

      load(12000, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step("d9999", 104 + 16 * i, 8, 1'b1);
         chk("d9999_const", 32'(last_ch), 32'h39);
      end

      rom_fixed = 1'b1;
      step("pix8", 8, 8, 1'b1);
      chk("pix8_char", 32'(last_ch), 32'h53);
      chk("pix8_row", 32'(last_row), 32'd0);
      chk("pix8_on", 32'(last_on), 32'd0);
      step("pix10", 10, 8, 1'b1);
      chk("pix10_on", 32'(last_on), 32'd1);
      rom_fixed = 1'b0;

      show_prompt = 1'b0;
      step("prompt_off", 216, 232, 1'b1);
      chk("prompt_off_char", 32'(last_ch), 32'h20);
      chk("prompt_off_on", 32'(last_on), 32'd0);
      show_prompt = 1'b1;
      step("prompt_on", 216, 232, 1'b1);
      chk("prompt_on_char", 32'(last_ch), 32'h50);

      step("col18", 296, 8, 1'b1);
      chk("col18_char", 32'(last_ch), 32'h20);
      chk("col18_on", 32'(last_on), 32'd0);
      lives = 3'd3;
      step("lives", 280, 8, 1'b1);
      chk("lives_char", 32'(last_ch), 32'h33);
      step("pv0", 104, 8, 1'b0);
      chk("pv0_on", 32'(last_on), 32'd0);
      chk("pv0_tvalid", 32'(last_tv), 32'd0);

      score = 14'd5555; score_load = 1'b1;
      @(negedge clk);
      score_load = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_score = 0;
      chk("abort_busy", 32'(bcd_busy), 32'd0);
      step("abort_digit", 104, 8, 1'b1);
      chk("abort_digit_const", 32'(last_ch), 32'h30);

      for (int r = 0; r < 8; r++) begin
         load(int'($urandom_range(0, 16383)), 1'b0);
         lives = 3'($urandom_range(0, 7));
         show_prompt = 1'($urandom_range(0, 1));
         for (int k = 0; k < 30; k++) begin
            sel = int'($urandom_range(0, 2));
            if (sel == 0) begin
               x = int'($urandom_range(0, 310)); y = int'($urandom_range(0, 30));
            end else if (sel == 1) begin
               x = int'($urandom_range(200, 440)); y = int'($urandom_range(225, 255));
            end else begin
               x = int'($urandom_range(0, 1023)); y = int'($urandom_range(0, 1023));
            end
            step("rand", x, y, 1'($urandom_range(0, 7) != 0));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
